// File: rtl/conv_frame_loader_pkg.sv
// Shared constants and types for the convolution frame loader: frame geometry,
// word type and controller state encoding.
package conv_pkg;
    localparam int INWIDTH = 16;
    localparam int IN_FRAC = 12;
    localparam int FIL_S   = 3;
    localparam int DI_W    = 7;
    localparam int DI_H    = 7;
    localparam int NF      = FIL_S * FIL_S;
    localparam int NI      = DI_W * DI_H;
    localparam int NT      = NF + NI;
    localparam int IDX_W   = $clog2(NT);
    localparam int CNT_W   = 16;

    typedef logic signed [INWIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD_FIL = 2'd0,
        LOAD_IFM = 2'd1,
        HOLD     = 2'd2,
        RESYNC   = 2'd3
    } state_e;
endpackage

// File: rtl/conv_frame_loader_if.sv
// Word-stream input and parallel-frame output handshakes of the frame loader.
interface conv_frame_loader_if;
    import conv_pkg::*;

    logic                   s_valid;
    logic                   s_ready;
    word_t                  s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [NF*INWIDTH-1:0]  filt_bus;
    logic [NI*INWIDTH-1:0]  ifm_bus;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, filt_bus, ifm_bus
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, filt_bus, ifm_bus
    );
endinterface

// File: rtl/conv_frame_loader_ctrl.sv
// Frame sequencing FSM: word index, framing-error detection, output valid and
// delivered-frame counter.
module conv_frame_ctrl
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             m_ready,
    output logic             s_ready,
    output logic             m_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [IDX_W-1:0] idx,
    output logic             wr_en
);
    localparam logic [1:0] ST_LOAD_FIL = LOAD_FIL;
    localparam logic [1:0] ST_LOAD_IFM = LOAD_IFM;
    localparam logic [1:0] ST_HOLD     = HOLD;
    localparam logic [1:0] ST_RESYNC   = RESYNC;

    localparam logic [IDX_W-1:0] IDX_FIL_END = IDX_W'(NF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NT - 1);

    logic [1:0] state;
    logic       xfer;

    assign s_ready = (state != ST_HOLD);
    assign xfer    = s_valid && s_ready;
    assign wr_en   = xfer && ((state == ST_LOAD_FIL) || (state == ST_LOAD_IFM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD_FIL;
            idx       <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_LOAD_FIL: begin
                    if (xfer) begin
                        if (s_last) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            if (idx == IDX_FIL_END)
                                state <= ST_LOAD_IFM;
                        end
                    end
                end
                ST_LOAD_IFM: begin
                    if (xfer) begin
                        if (idx == IDX_LAST) begin
                            // Full-length frame: deliver only if it is properly terminated
                            if (s_last) begin
                                state   <= ST_HOLD;
                                m_valid <= 1'b1;
                            end else begin
                                state     <= ST_RESYNC;
                                frame_err <= 1'b1;
                                idx       <= '0;
                            end
                        end else if (s_last) begin
                            state     <= ST_LOAD_FIL;
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        idx       <= '0;
                        state     <= ST_LOAD_FIL;
                    end
                end
                ST_RESYNC: begin
                    if (xfer && s_last) begin
                        idx   <= '0;
                        state <= ST_LOAD_FIL;
                    end
                end
                default: state <= ST_LOAD_FIL;
            endcase
        end
    end
endmodule

// File: rtl/conv_frame_loader.sv
// Frame loader top: filter and ifmap register buffers written in place from the
// word stream and presented as flat parallel buses.
module conv_frame_loader
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    conv_frame_loader_if.slave   bus,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt
);
    word_t            fil_mem [NF];
    word_t            ifm_mem [NI];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ifm_slot;
    logic             wr_en;
    logic             s_ready_w;
    logic             m_valid_w;

    conv_frame_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (bus.s_valid),
        .s_last    (bus.s_last),
        .m_ready   (bus.m_ready),
        .s_ready   (s_ready_w),
        .m_valid   (m_valid_w),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .idx       (idx),
        .wr_en     (wr_en)
    );

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_w;
    assign ifm_slot    = idx - IDX_W'(NF);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NF; i++) fil_mem[i] <= '0;
            for (int i = 0; i < NI; i++) ifm_mem[i] <= '0;
        end else if (wr_en) begin
            // Indices below NF address the filter, the rest map onto the ifmap
            if (idx < IDX_W'(NF)) begin
                for (int i = 0; i < NF; i++)
                    if (idx == IDX_W'(i)) fil_mem[i] <= bus.s_data;
            end else begin
                for (int i = 0; i < NI; i++)
                    if (ifm_slot == IDX_W'(i)) ifm_mem[i] <= bus.s_data;
            end
        end
    end

    always_comb begin
        bus.filt_bus = '0;
        for (int i = 0; i < NF; i++)
            bus.filt_bus[i*INWIDTH +: INWIDTH] = fil_mem[i];
    end

    always_comb begin
        bus.ifm_bus = '0;
        for (int i = 0; i < NI; i++)
            bus.ifm_bus[i*INWIDTH +: INWIDTH] = ifm_mem[i];
    end
endmodule

// File: tb/tb_conv_frame_loader.sv
// Bench for conv_frame_loader: randomized word streams against a queue-based
// frame model, plus directed framing-error and reset scenarios.
module tb_conv_frame_loader;
    import conv_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;

    conv_frame_loader_if ifc();

    conv_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.slave),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int mv_seen = 0;

    // Reference model: words collected per frame, frame length and s_last decide the outcome
    bit          m_hold = 0;
    bit          m_resync = 0;
    bit          m_err = 0;
    int unsigned m_cnt = 0;
    logic [15:0] m_q [$];
    logic [15:0] m_frame [$];

    logic [15:0] fr [NT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 0; m_resync = 0; m_err = 0; m_cnt = 0;
            m_q.delete();
        end else begin
            m_err = 0;
            if (m_hold) begin
                if (ifc.m_ready) begin
                    m_hold = 0;
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end else if (ifc.s_valid) begin
                if (m_resync) begin
                    if (ifc.s_last) m_resync = 0;
                end else begin
                    m_q.push_back(ifc.s_data);
                    if (ifc.s_last) begin
                        if (m_q.size() == NT) begin
                            m_hold = 1;
                            m_frame = m_q;
                        end else begin
                            m_err = 1;
                        end
                        m_q.delete();
                    end else if (m_q.size() == NT) begin
                        m_err = 1;
                        m_resync = 1;
                        m_q.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int bad;
        check("s_ready", 64'(ifc.s_ready), 64'(!m_hold));
        check("m_valid", 64'(ifc.m_valid), 64'(m_hold));
        check("frame_err", 64'(frame_err), 64'(m_err));
        check("frame_cnt", 64'(frame_cnt), 64'(m_cnt[15:0]));
        err_seen += int'(frame_err === 1'b1);
        mv_seen  += int'(ifc.m_valid === 1'b1);
        if (m_hold) begin
            bad = -1;
            for (int i = 0; i < NF; i++)
                if (bad < 0 && ifc.filt_bus[i*INWIDTH +: INWIDTH] !== m_frame[i]) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL filt_bus word %0d: got %h expected %h", bad,
                         ifc.filt_bus[bad*INWIDTH +: INWIDTH], m_frame[bad]);
            end
            bad = -1;
            for (int i = 0; i < NI; i++)
                if (bad < 0 && ifc.ifm_bus[i*INWIDTH +: INWIDTH] !== m_frame[NF+i]) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL ifm_bus word %0d: got %h expected %h", bad,
                         ifc.ifm_bus[bad*INWIDTH +: INWIDTH], m_frame[NF+bad]);
            end
        end
    end

    task automatic put(input logic [15:0] d, input bit last, input int gap_pct);
        bit acc = 0;
        int t = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            ifc.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        ifc.s_valid = 1'b1;
        ifc.s_data  = d;
        ifc.s_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc = (ifc.s_ready === 1'b1);
            @(posedge clk); #1;
            t++;
            if (!acc && t > 200) begin
                vectors++; miscompares++;
                $display("FAIL put_timeout: got no s_ready required s_ready within 200 cycles");
                break;
            end
        end
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int i = 0; i < NT; i++) put(fr[i], i == NT - 1, gap_pct);
    endtask

    task automatic wait_mvalid();
        int t = 0;
        while (ifc.m_valid !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            vectors++; miscompares++;
            $display("FAIL mvalid_timeout: got m_valid=0 required m_valid=1 within 200 cycles");
        end
    endtask

    task automatic handshake(input int stall);
        wait_mvalid();
        repeat (stall) begin
            @(posedge clk); #1;
        end
        ifc.m_ready = 1'b1;
        @(posedge clk); #1;
        ifc.m_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NT; i++) fr[i] = 16'($urandom);
        fr[$urandom_range(NT-1)] = 16'h8000;
        fr[$urandom_range(NT-1)] = 16'h7FFF;
        fr[$urandom_range(NT-1)] = 16'h0000;
    endtask

    initial begin
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.s_last  = 1'b0;
        ifc.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s_ready", 64'(ifc.s_ready), 64'(1));
        check("reset_filt_bus", 64'(ifc.filt_bus[63:0]), 64'(0));
        rst = 1'b0;

        // Sequential frame 1..58, delivered immediately
        for (int i = 0; i < NT; i++) fr[i] = 16'(i + 1);
        send_frame(0);
        check("t1_m_valid", 64'(ifc.m_valid), 64'(1));
        check("t1_filt00", 64'(ifc.filt_bus[0 +: 16]), 64'(1));
        check("t1_filt22", 64'(ifc.filt_bus[8*16 +: 16]), 64'(9));
        check("t1_ifm00", 64'(ifc.ifm_bus[0 +: 16]), 64'(10));
        check("t1_ifm66", 64'(ifc.ifm_bus[48*16 +: 16]), 64'(58));
        handshake(0);
        check("t1_frame_cnt", 64'(frame_cnt), 64'(1));

        // Same frame held against a stalled consumer
        send_frame(0);
        handshake(5);
        check("t2_frame_cnt", 64'(frame_cnt), 64'(2));

        // Early s_last on word 20
        err_seen = 0; mv_seen = 0;
        for (int i = 0; i < 20; i++) put(16'(i + 1), i == 19, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_err_pulses", 64'(err_seen), 64'(1));
        check("t3_no_mvalid", 64'(mv_seen), 64'(0));
        fill_random();
        send_frame(0);
        handshake(1);

        // Missing s_last, then junk up to a stray s_last
        err_seen = 0; mv_seen = 0;
        for (int i = 0; i < NT; i++) put(16'(i + 100), 1'b0, 0);
        for (int i = 0; i < 3; i++) put(16'hDEAD, i == 2, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_pulses", 64'(err_seen), 64'(1));
        check("t4_no_mvalid", 64'(mv_seen), 64'(0));
        fill_random();
        send_frame(0);
        handshake(2);

        // Random gaps over four frames
        pulse_reset();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            send_frame(50);
            handshake($urandom_range(3));
        end
        @(negedge clk);
        check("t5_frame_cnt", 64'(frame_cnt), 64'(4));

        // Reset while holding, then mid-load
        @(posedge clk); #1;
        fill_random();
        send_frame(0);
        wait_mvalid();
        pulse_reset();
        check("t6_hold_m_valid", 64'(ifc.m_valid), 64'(0));
        check("t6_hold_frame_cnt", 64'(frame_cnt), 64'(0));
        for (int i = 0; i < 30; i++) put(16'(i + 500), 1'b0, 0);
        pulse_reset();
        check("t6_mid_m_valid", 64'(ifc.m_valid), 64'(0));
        for (int i = 0; i < NT; i++) fr[i] = 16'(i + 1000);
        send_frame(0);
        check("t6_filt00", 64'(ifc.filt_bus[0 +: 16]), 64'(1000));
        handshake(0);
        check("t6_frame_cnt", 64'(frame_cnt), 64'(1));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
